// File: rtl/nv_afifo_pkg.sv
// nv_afifo_pkg: pointer width derivation and Gray/binary helpers shared by both FIFO controllers
package nv_afifo_pkg;
    localparam int PTR_MAX = 32;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b = g;
        for (int i = PTR_MAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/nv_afifo_rd_ctrl_if.sv
// nv_afifo_rd_ctrl_if: read-side FIFO signals (pointer exchange, RAM read port, payload handshake)
interface nv_afifo_rd_ctrl_if #(parameter int DEPTH = 16, parameter int DW = 32);
    import nv_afifo_pkg::*;
    localparam int AW = aw_of(DEPTH);
    logic [AW:0]    wr_ptr_gray;
    logic [AW:0]    rd_ptr_gray;
    logic           ram_re;
    logic [AW-1:0]  ram_ra;
    logic [DW-1:0]  ram_dout;
    logic           ram_clk_en;
    logic           dft_enable_r;
    logic           rd_pvld;
    logic           rd_prdy;
    logic [DW-1:0]  rd_pd;
    logic [AW:0]    rd_count;

    modport master (
        input  wr_ptr_gray, ram_dout, dft_enable_r, rd_prdy,
        output rd_ptr_gray, ram_re, ram_ra, ram_clk_en, rd_pvld, rd_pd, rd_count
    );

    modport slave (
        output wr_ptr_gray, ram_dout, dft_enable_r, rd_prdy,
        input  rd_ptr_gray, ram_re, ram_ra, ram_clk_en, rd_pvld, rd_pd, rd_count
    );
endinterface

// File: rtl/nv_afifo_sync2.sv
// nv_afifo_sync2: two-flop synchroniser bringing a Gray pointer into the local clock domain
module nv_afifo_sync2 #(parameter int WIDTH = 1) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] m;

    // first stage may go metastable; second stage feeds the consuming logic
    always_ff @(posedge clk) begin
        if (rst) begin
            m <= '0;
            q <= '0;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/nv_afifo_rd_ctrl.sv
// nv_afifo_rd_ctrl: async FIFO read controller with a two-entry registered output buffer
module nv_afifo_rd_ctrl
    import nv_afifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic               rd_clk,
    input  logic               rd_reset,
    nv_afifo_rd_ctrl_if.master io
);
    localparam int AW = aw_of(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_gray_s, wr_bin_s, rd_bin, rd_gray;
    logic [DW-1:0] b0, b1, s0;
    logic [1:0]    buf_cnt, c_pop, buf_nx;
    logic          inflight, pop, empty, re, pvld;

    nv_afifo_sync2 #(.WIDTH(PW)) u_sync (
        .clk(rd_clk),
        .rst(rd_reset),
        .d(io.wr_ptr_gray),
        .q(wr_gray_s)
    );

    assign wr_bin_s = PW'(gray2bin(PTR_MAX'(wr_gray_s)));
    assign empty    = wr_bin_s == rd_bin;
    assign pop      = pvld & io.rd_prdy;
    assign c_pop    = buf_cnt - {1'b0, pop};
    assign buf_nx   = c_pop + {1'b0, inflight};
    assign re       = !empty && buf_nx < 2'd2;
    assign s0       = pop ? b1 : b0;

    assign io.ram_re      = re;
    assign io.ram_ra      = rd_bin[AW-1:0];
    assign io.ram_clk_en  = io.dft_enable_r & re;
    assign io.rd_ptr_gray = rd_gray;
    assign io.rd_pvld     = pvld;
    assign io.rd_pd       = b0;
    assign io.rd_count    = wr_bin_s - rd_bin;

    // read pointer advances per fetch; its Gray copy is registered for the write side
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            rd_bin   <= '0;
            rd_gray  <= '0;
            inflight <= 1'b0;
        end else begin
            rd_bin   <= rd_bin + PW'(re);
            rd_gray  <= PW'(bin2gray(PTR_MAX'(rd_bin)));
            inflight <= re;
        end
    end

    // pop shifts skid into head; returning RAM word lands in the first free slot after the pop
    always_ff @(posedge rd_clk) begin
        if (rd_reset) begin
            b0      <= '0;
            b1      <= '0;
            buf_cnt <= 2'd0;
            pvld    <= 1'b0;
        end else begin
            b0      <= (inflight && c_pop == 2'd0) ? io.ram_dout : s0;
            b1      <= (inflight && c_pop == 2'd1) ? io.ram_dout : b1;
            buf_cnt <= buf_nx;
            pvld    <= buf_nx != 2'd0;
        end
    end

    // fetch throttling must never deliver a word into an already full buffer
    assert property (@(posedge rd_clk) disable iff (rd_reset) !(inflight && c_pop == 2'd2));
endmodule

// File: tb/tb_nv_afifo_rd_ctrl.sv
// tb_nv_afifo_rd_ctrl: directed checks of the async FIFO read controller
module tb_nv_afifo_rd_ctrl;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int wr_seq = 0;
    int rd_seq = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0] wbin = '0;

    nv_afifo_rd_ctrl_if #(.DEPTH(DEPTH), .DW(DW)) io ();
    nv_afifo_rd_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (.rd_clk(clk), .rd_reset(rst), .io(io));

    always #5 clk = ~clk;

    always @(posedge clk) if (io.ram_re) io.ram_dout <= mem[io.ram_ra];

    function automatic logic [DW-1:0] word(input int s);
        return 32'(32'hA500_0000 + s * 7);
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wbin[AW-1:0]] = word(wr_seq);
            wr_seq++;
            wbin++;
        end
        io.wr_ptr_gray = wbin ^ (wbin >> 1);
    endtask

    task automatic drain(input int n, input string tag);
        int got = 0;
        for (int c = 0; c < 40 && got < n; c++) begin
            @(negedge clk);
            if (io.rd_pvld && io.rd_prdy) begin
                n_cmp++;
                if (io.rd_pd !== word(rd_seq)) begin
                    n_bad++;
                    $display("FAIL %s pop %0d: got %h want %h", tag, rd_seq, io.rd_pd, word(rd_seq));
                end
                rd_seq++;
                got++;
            end
        end
        n_cmp++;
        if (got != n) begin
            n_bad++;
            $display("FAIL %s count: got %0d pops want %0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        io.wr_ptr_gray = '0;
        io.rd_prdy = 1'b0;
        io.dft_enable_r = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (io.rd_pvld !== 1'b0) begin n_bad++; $display("FAIL reset_pvld: got %b want 0", io.rd_pvld); end
        n_cmp++;
        if (io.ram_re !== 1'b0) begin n_bad++; $display("FAIL reset_re: got %b want 0", io.ram_re); end
        n_cmp++;
        if (io.rd_pd !== '0) begin n_bad++; $display("FAIL reset_pd: got %h want 0", io.rd_pd); end
        n_cmp++;
        if (io.rd_count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", io.rd_count); end
        n_cmp++;
        if (io.rd_ptr_gray !== '0) begin n_bad++; $display("FAIL reset_gray: got %h want 0", io.rd_ptr_gray); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_latency();
        logic exp_re, exp_pv;
        io.rd_prdy = 1'b1;
        push(3);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            exp_re = k >= 2 && k <= 4;
            exp_pv = k >= 4 && k <= 6;
            n_cmp++;
            if (io.ram_re !== exp_re) begin n_bad++; $display("FAIL lat_re k=%0d: got %b want %b", k, io.ram_re, exp_re); end
            n_cmp++;
            if (io.ram_clk_en !== exp_re) begin n_bad++; $display("FAIL lat_clk_en k=%0d: got %b want %b", k, io.ram_clk_en, exp_re); end
            if (exp_re) begin
                n_cmp++;
                if (io.ram_ra !== AW'(k - 2)) begin n_bad++; $display("FAIL lat_ra k=%0d: got %0d want %0d", k, io.ram_ra, k - 2); end
            end
            n_cmp++;
            if (io.rd_pvld !== exp_pv) begin n_bad++; $display("FAIL lat_pvld k=%0d: got %b want %b", k, io.rd_pvld, exp_pv); end
            if (exp_pv) begin
                n_cmp++;
                if (io.rd_pd !== word(rd_seq)) begin n_bad++; $display("FAIL lat_pd k=%0d: got %h want %h", k, io.rd_pd, word(rd_seq)); end
                rd_seq++;
            end
        end
        n_cmp++;
        if (io.rd_count !== '0) begin n_bad++; $display("FAIL lat_count: got %0d want 0", io.rd_count); end
    endtask

    task automatic test_full();
        int re_cnt = 0;
        @(posedge clk);
        #1 io.rd_prdy = 1'b0;
        push(5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (io.ram_re) re_cnt++;
            if (io.rd_pvld) begin
                n_cmp++;
                if (io.rd_pd !== word(rd_seq)) begin n_bad++; $display("FAIL full_hold k=%0d: got %h want %h", k, io.rd_pd, word(rd_seq)); end
            end
        end
        n_cmp++;
        if (re_cnt != 2) begin n_bad++; $display("FAIL full_re_cnt: got %0d want 2", re_cnt); end
        n_cmp++;
        if (io.rd_pvld !== 1'b1) begin n_bad++; $display("FAIL full_pvld: got %b want 1", io.rd_pvld); end
        n_cmp++;
        if (io.rd_count !== 5'd3) begin n_bad++; $display("FAIL full_count: got %0d want 3", io.rd_count); end
        @(posedge clk);
        #1 io.rd_prdy = 1'b1;
        drain(5, "full_drain");
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_ra [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        logic [AW:0]   exp_g  [4] = '{5'b10000, 5'b00000, 5'b00001, 5'b00011};
        logic [AW:0]   prev_g;
        int n_re = 0;
        int n_g = 0;
        int first_k = -1;
        int last_k = -1;
        io.rd_prdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1 push(11);
            drain(11, "wrap_pre");
        end
        @(posedge clk);
        #1 prev_g = io.rd_ptr_gray;
        n_cmp++;
        if (prev_g !== 5'b10001) begin n_bad++; $display("FAIL wrap_start_gray: got %b want 10001", prev_g); end
        push(4);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (io.ram_re) begin
                if (n_re < 4) begin
                    n_cmp++;
                    if (io.ram_ra !== exp_ra[n_re]) begin n_bad++; $display("FAIL wrap_ra %0d: got %0d want %0d", n_re, io.ram_ra, exp_ra[n_re]); end
                end
                if (first_k < 0) first_k = k;
                last_k = k;
                n_re++;
            end
            if (io.rd_ptr_gray !== prev_g) begin
                if (n_g < 4) begin
                    n_cmp++;
                    if (io.rd_ptr_gray !== exp_g[n_g]) begin n_bad++; $display("FAIL wrap_gray %0d: got %b want %b", n_g, io.rd_ptr_gray, exp_g[n_g]); end
                end
                prev_g = io.rd_ptr_gray;
                n_g++;
            end
            if (io.rd_pvld && io.rd_prdy) begin
                n_cmp++;
                if (io.rd_pd !== word(rd_seq)) begin n_bad++; $display("FAIL wrap_pop %0d: got %h want %h", rd_seq, io.rd_pd, word(rd_seq)); end
                rd_seq++;
            end
        end
        n_cmp++;
        if (n_re != 4 || last_k - first_k != 3) begin n_bad++; $display("FAIL wrap_burst: got %0d reads over %0d cycles want 4 over 3", n_re, last_k - first_k); end
        n_cmp++;
        if (n_g != 4) begin n_bad++; $display("FAIL wrap_gray_steps: got %0d want 4", n_g); end
        n_cmp++;
        if (rd_seq != wr_seq) begin n_bad++; $display("FAIL wrap_drained: got %0d want %0d", rd_seq, wr_seq); end
    endtask

    task automatic test_dft();
        int n_re = 0;
        int n_en = 0;
        @(posedge clk);
        #1 io.dft_enable_r = 1'b0;
        io.rd_prdy = 1'b1;
        push(6);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (io.ram_re) n_re++;
            if (io.ram_clk_en !== 1'b0) n_en++;
            if (io.rd_pvld && io.rd_prdy) begin
                n_cmp++;
                if (io.rd_pd !== word(rd_seq)) begin n_bad++; $display("FAIL dft_pop %0d: got %h want %h", rd_seq, io.rd_pd, word(rd_seq)); end
                rd_seq++;
            end
        end
        n_cmp++;
        if (n_en != 0) begin n_bad++; $display("FAIL dft_clk_en: got %0d enabled cycles want 0", n_en); end
        n_cmp++;
        if (n_re != 6) begin n_bad++; $display("FAIL dft_re_cnt: got %0d want 6", n_re); end
        n_cmp++;
        if (rd_seq != wr_seq) begin n_bad++; $display("FAIL dft_drained: got %0d want %0d", rd_seq, wr_seq); end
        @(posedge clk);
        #1 io.dft_enable_r = 1'b1;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int n_pv = 0;
        @(posedge clk);
        #1 io.rd_prdy = 1'b0;
        push(5);
        do begin
            @(negedge clk);
            k++;
        end while (!io.rd_pvld && k < 10);
        n_cmp++;
        if (io.rd_pvld !== 1'b1) begin n_bad++; $display("FAIL rstmid_fill: got pvld %b want 1", io.rd_pvld); end
        @(posedge clk);
        #1 rst = 1'b1;
        wbin = '0;
        io.wr_ptr_gray = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        io.rd_prdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (io.rd_count !== '0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", io.rd_count); end
        for (int c = 0; c < 6; c++) begin
            if (io.rd_pvld !== 1'b0) n_pv++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_pv != 0) begin n_bad++; $display("FAIL rstmid_stale: got %0d valid cycles want 0", n_pv); end
        rd_seq = wr_seq;
        @(posedge clk);
        #1 push(2);
        drain(2, "rstmid_after");
    endtask

    task automatic test_random();
        int target;
        logic stalled = 1'b0;
        logic [DW-1:0] hold = '0;
        target = wr_seq + 1000;
        for (int c = 0; c < 30000 && rd_seq < target; c++) begin
            @(posedge clk);
            #1 io.rd_prdy = 1'($urandom_range(0, 1));
            if (wr_seq < target && wr_seq - rd_seq < DEPTH && $urandom_range(0, 3) != 0) push(1);
            @(negedge clk);
            if (stalled) begin
                n_cmp++;
                if (io.rd_pvld !== 1'b1 || io.rd_pd !== hold) begin
                    n_bad++;
                    $display("FAIL rand_stall: got pvld %b pd %h want 1 %h", io.rd_pvld, io.rd_pd, hold);
                end
            end
            if (io.rd_pvld && io.rd_prdy) begin
                n_cmp++;
                if (io.rd_pd !== word(rd_seq)) begin n_bad++; $display("FAIL rand_pop %0d: got %h want %h", rd_seq, io.rd_pd, word(rd_seq)); end
                rd_seq++;
            end
            stalled = io.rd_pvld && !io.rd_prdy;
            hold = io.rd_pd;
        end
        n_cmp++;
        if (rd_seq != target) begin n_bad++; $display("FAIL rand_done: got %0d words want %0d", rd_seq, target); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full();
        test_wrap();
        test_dft();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
